pmem_line_responder: RTL and testbench

- Memory-side responder for the 256-bit cache-line physical memory interface driven by cache_hierarchy.
- Accepts one line read or line write at a time, waits a parameterised latency, then returns a single-cycle pmem_resp.
- Holds lines in an internal array with per-line valid bits.
- Used as the synthesizable backing memory in system-level benches and FPGA bring-up, in place of the behavioural memory model.

---
 rtl/pmem_line_responder_pkg.sv | 17 +
 rtl/pmem_line_responder_if.sv | 27 ++
 rtl/pmem_line_responder_line_array.sv | 50 +++++
 rtl/pmem_line_responder.sv | 113 +++++++++++
 tb/tb_pmem_line_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the cache-line physical memory responder.
// Line geometry: 256-bit lines, byte offset bits [4:0] ignored.
// FSM state encoding shared between the top and any future sub-blocks.
package pmem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;

  typedef logic [LINE_BITS-1:0] pmem_line_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_if.sv
// Line-granular pmem bus between the cache hierarchy (master) and memory (slave).
// Requests are level-held until the one-cycle pmem_resp pulse.
// busy/protocol_error are memory-side status outputs.
interface pmem_line_responder_if
  import pmem_pkg::*;
();

  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  pmem_line_t  pmem_wdata;
  logic        pmem_resp;
  pmem_line_t  pmem_rdata;
  logic        busy;
  logic        protocol_error;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, busy, protocol_error
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, busy, protocol_error
  );

endinterface

// File: rtl/pmem_line_responder_line_array.sv
// Single-port line store with per-line valid bits and a synchronous valid clear.
// Latency: one cycle; rdata is registered and reads zero unless a read hit the previous edge.
// No backpressure: one access per enabled cycle.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] idx,
  input  pmem_line_t            wdata,
  output pmem_line_t            rdata
);

  localparam int DEPTH = 1 << INDEX_BITS;

  pmem_line_t       mem [DEPTH];
  logic [DEPTH-1:0] vld_q;

  // Line storage is deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  // Valid bits: cleared on reset, set by each line write.
  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= '0;
    end else if (en && we) begin
      vld_q[idx] <= 1'b1;
    end
  end

  // Registered read port; holds a value for exactly the cycle after a read, else zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (en && !we && vld_q[idx]) begin
      rdata <= mem[idx];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side pmem responder: one line read/write at a time from an internal line array.
// Latency: pmem_resp rises LATENCY cycles after the request is first seen in IDLE.
// Backpressure: requests are held by the master; inputs are ignored while busy.
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int LATENCY    = 10,
  parameter int INDEX_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  pmem_line_responder_if.slave    bus
);

  localparam int             CNT_INIT_I = (LATENCY >= 2) ? LATENCY - 2 : 0;
  localparam logic [7:0]     CNT_INIT   = CNT_INIT_I[7:0];

  pmem_state_t           state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  pmem_line_t            wdata_q, wdata_d;
  logic                  perr_q, perr_d;
  logic                  accept;
  logic                  arr_en;
  logic                  unused_addr_bits;

  // Higher address bits alias and the byte offset is irrelevant at line granularity.
  assign unused_addr_bits = ^{bus.pmem_address[31:OFFSET_BITS+INDEX_BITS],
                              bus.pmem_address[OFFSET_BITS-1:0]};

  // Next-state, request latching and array-access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    perr_d  = perr_q;
    accept  = 1'b0;
    arr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pmem_read ^ bus.pmem_write) begin
          accept  = 1'b1;
          op_wr_d = bus.pmem_write;
          idx_d   = bus.pmem_address[OFFSET_BITS +: INDEX_BITS];
          wdata_d = bus.pmem_wdata;
          if (LATENCY == 1) begin
            state_d = RESP;
            arr_en  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end else if (bus.pmem_read && bus.pmem_write) begin
          perr_d = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          arr_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and request latches; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
    end
  end

  // The _d values carry the freshly accepted request when LATENCY=1 skips WAIT.
  pmem_line_array #(
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk   (clk),
    .clr   (rst),
    .en    (arr_en && !rst),
    .we    (op_wr_d),
    .idx   (idx_d),
    .wdata (wdata_d),
    .rdata (bus.pmem_rdata)
  );

  assign bus.pmem_resp      = (state_q == RESP);
  assign bus.busy           = (state_q != IDLE) || (accept && !rst);
  assign bus.protocol_error = perr_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: directed table, multi-cycle corner sequences, randomized traffic.
// Two instances (LATENCY=10 and LATENCY=1) share clock and reset.
// Expected data comes from a line-indexed reference memory kept in the bench.
module tb_pmem_line_responder;
  import pmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_line_responder_if bus10 ();
  pmem_line_responder_if bus1 ();

  pmem_line_responder #(.LATENCY(10), .INDEX_BITS(6)) u_dut10 (
    .clk (clk), .rst (rst), .bus (bus10)
  );
  pmem_line_responder #(.LATENCY(1), .INDEX_BITS(6)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory: one entry per line index, per instance.
  pmem_line_t mdl_mem [2][64];
  bit         mdl_vld [2][64];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    pmem_line_t  wdata;
    pmem_line_t  exp_rdata;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input pmem_line_t wd);
    if (sel == 0) begin
      bus10.pmem_read = rd; bus10.pmem_write = wr; bus10.pmem_address = a; bus10.pmem_wdata = wd;
    end else begin
      bus1.pmem_read = rd; bus1.pmem_write = wr; bus1.pmem_address = a; bus1.pmem_wdata = wd;
    end
  endtask

  task automatic sample(input int sel, output logic resp, output logic busy,
                        output logic perr, output pmem_line_t rd);
    if (sel == 0) begin
      resp = bus10.pmem_resp; busy = bus10.busy; perr = bus10.protocol_error; rd = bus10.pmem_rdata;
    end else begin
      resp = bus1.pmem_resp; busy = bus1.busy; perr = bus1.protocol_error; rd = bus1.pmem_rdata;
    end
  endtask

  function automatic pmem_line_t mdl_read(input int sel, input logic [31:0] a);
    logic [5:0] idx;
    idx = a[10:5];
    return mdl_vld[sel][idx] ? mdl_mem[sel][idx] : '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) mdl_vld[s][i] = 1'b0;
  endtask

  // Runs one transaction from the start of its cycle 0 and checks every cycle through LATENCY+1.
  // drop_at > 0 releases the request at that cycle (must not cancel the operation).
  task automatic do_txn(input string tag, input int sel, input bit wr, input logic [31:0] a,
                        input pmem_line_t wd, input pmem_line_t exp, input int drop_at,
                        output int resp_cyc);
    int lat;
    logic resp, busy, perr;
    pmem_line_t rd;
    lat = (sel == 0) ? 10 : 1;
    resp_cyc = -1;
    set_req(sel, !wr, wr, a, wd);
    for (int k = 0; k <= lat + 1; k++) begin
      if (drop_at > 0 && k == drop_at) set_req(sel, 1'b0, 1'b0, a, wd);
      @(negedge clk);
      sample(sel, resp, busy, perr, rd);
      check($sformatf("%s.resp.k%0d", tag, k), resp, (k == lat));
      check($sformatf("%s.busy.k%0d", tag, k), busy, (k <= lat));
      check($sformatf("%s.rdata.k%0d", tag, k), rd, (k == lat) ? exp : '0);
      if (resp) resp_cyc = cyc;
      next_cycle();
      if (k == lat) set_req(sel, 1'b0, 1'b0, a, wd);
    end
    if (wr) begin
      mdl_mem[sel][a[10:5]] = wd;
      mdl_vld[sel][a[10:5]] = 1'b1;
    end
  endtask

  initial begin
    int rc [6];
    int rcx;
    int resp_seen;
    logic resp, busy, perr;
    pmem_line_t rd, exp, wd;
    logic [31:0] a;
    int sel, drop, gap;
    bit wr;

    tbl[0] = '{1'b0, 32'h0000_0040, '0, '0};
    tbl[1] = '{1'b1, 32'h0000_0060, {8{32'hDEADBEEF}}, '0};
    tbl[2] = '{1'b0, 32'h0000_0060, '0, {8{32'hDEADBEEF}}};
    tbl[3] = '{1'b1, 32'h0000_0820, {4{64'h0123_4567_89AB_CDEF}}, '0};
    tbl[4] = '{1'b0, 32'h0000_003F, '0, {4{64'h0123_4567_89AB_CDEF}}};
    tbl[5] = '{1'b0, 32'h0000_1060, '0, {8{32'hDEADBEEF}}};

    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    do_reset();

    // Reset state of both instances.
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sample(s, resp, busy, perr, rd);
      check($sformatf("rst%0d.resp", s), resp, 1'b0);
      check($sformatf("rst%0d.busy", s), busy, 1'b0);
      check($sformatf("rst%0d.perr", s), perr, 1'b0);
      check($sformatf("rst%0d.rdata", s), rd, '0);
      next_cycle();
    end

    // Directed table on the LATENCY=10 instance.
    for (int i = 0; i < 6; i++) begin
      do_txn($sformatf("tbl%0d", i), 0, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rdata, 0, rc[i]);
    end
    check("tbl.wr_rd_gap_ge11", ((rc[2] - rc[1]) >= 11), 1'b1);

    // LATENCY=1: store a line, then hold read across three back-to-back requests.
    do_txn("l1.wr", 1, 1'b1, 32'h0000_0020, {8{32'h1357_9BDF}}, '0, 0, rcx);
    exp = mdl_read(1, 32'h0000_0020);
    set_req(1, 1'b1, 1'b0, 32'h0000_0020, '0);
    for (int k = 0; k <= 6; k++) begin
      if (k == 5) set_req(1, 1'b0, 1'b0, 32'h0000_0020, '0);
      @(negedge clk);
      sample(1, resp, busy, perr, rd);
      check($sformatf("l1.b2b.resp.k%0d", k), resp, (k == 1 || k == 3 || k == 5));
      check($sformatf("l1.b2b.busy.k%0d", k), busy, (k <= 5));
      check($sformatf("l1.b2b.rdata.k%0d", k), rd, (k == 1 || k == 3 || k == 5) ? exp : '0);
      next_cycle();
    end

    // Protocol error: both request lines high in IDLE are refused and latch the error.
    set_req(0, 1'b1, 1'b1, 32'h0000_0040, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      sample(0, resp, busy, perr, rd);
      check($sformatf("perr.busy.k%0d", k), busy, 1'b0);
      check($sformatf("perr.resp.k%0d", k), resp, 1'b0);
      check($sformatf("perr.flag.k%0d", k), perr, (k >= 1));
      next_cycle();
    end
    set_req(0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    do_txn("perr.legal", 0, 1'b0, 32'h0000_0060, '0, mdl_read(0, 32'h0000_0060), 0, rcx);
    @(negedge clk);
    sample(0, resp, busy, perr, rd);
    check("perr.sticky", perr, 1'b1);
    sample(1, resp, busy, perr, rd);
    check("perr.other_inst_clear", perr, 1'b0);
    next_cycle();

    // Reset in the middle of a write: no resp, line not stored, error flag cleared.
    set_req(0, 1'b0, 1'b1, 32'h0000_0060, {8{32'hCAFE_F00D}});
    for (int k = 0; k < 4; k++) next_cycle();
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    next_cycle();
    rst = 1'b0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 64; i++) mdl_vld[s][i] = 1'b0;
    resp_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus10.pmem_resp) resp_seen++;
      next_cycle();
    end
    check("rstmid.no_resp", resp_seen, 0);
    @(negedge clk);
    sample(0, resp, busy, perr, rd);
    check("rstmid.perr", perr, 1'b0);
    next_cycle();
    do_txn("rstmid.rd", 0, 1'b0, 32'h0000_0060, '0, 256'h0, 0, rcx);

    // Randomized traffic against the reference memory, with aliasing and mid-WAIT drops.
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      a   = $urandom();
      a[10:5] = 6'($urandom_range(0, 7));
      wd  = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      drop = $urandom_range(0, (sel == 0) ? 10 : 1);
      exp = wr ? '0 : mdl_read(sel, a);
      do_txn($sformatf("rnd%0d", t), sel, wr, a, wr ? wd : '0, exp, drop, rcx);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
